// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin burst scheduler in front of a 2-bit-select 1:4 Demux.
// Accepts a valid/ready word stream and holds one word until its channel is ready.
// Optional macro DEMUX_SCHED_CNT_EN adds saturating per-channel transfer counters on cnt_flat.
module demux_rr_scheduler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        ch_en,
    input  logic [3:0]        out_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              demux_in,
    output logic              busy,
    output logic [63:0]       cnt_flat
);

    localparam logic [8:0] BurstLen9 = 9'(BURST_LEN);

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [1:0]        hold_dst_q, hold_dst_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic       pick_ok;
    logic [1:0] pick;
    logic       xfer;
    logic       accept;
    logic [8:0] cnt_inc;

    // Channel choice: first enabled channel at or after ptr, wrapping mod 4.
    always_comb begin
        pick = ptr_q;
        // Walk downwards so the smallest offset from ptr wins.
        for (int k = 3; k >= 0; k--) begin
            if (ch_en[ptr_q + 2'(k)]) begin
                pick = ptr_q + 2'(k);
            end
        end
    end

    assign pick_ok  = |ch_en;
    assign xfer     = hold_valid_q & out_ready[hold_dst_q];
    assign in_ready = pick_ok & (~hold_valid_q | out_ready[hold_dst_q]);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = {1'b0, burst_cnt_q} + 9'd1;

    // Next-state for the holding register, pointer and burst counter.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_dst_d   = hold_dst_q;
        ptr_d        = ptr_q;
        burst_cnt_d  = burst_cnt_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            hold_dst_d   = pick;
            if (pick != ptr_q) begin
                // A skip restarts the burst on the newly picked channel.
                if (BURST_LEN == 1) begin
                    ptr_d       = pick + 2'd1;
                    burst_cnt_d = 8'd0;
                end else begin
                    ptr_d       = pick;
                    burst_cnt_d = 8'd1;
                end
            end else if (cnt_inc == BurstLen9) begin
                ptr_d       = pick + 2'd1;
                burst_cnt_d = 8'd0;
            end else begin
                burst_cnt_d = cnt_inc[7:0];
            end
        end else if (xfer) begin
            hold_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_dst_q   <= 2'd0;
            ptr_q        <= 2'd0;
            burst_cnt_q  <= 8'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_dst_q   <= hold_dst_d;
            ptr_q        <= ptr_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Output decode; sel encoding is fixed by the Demux wiring.
    always_comb begin
        out_valid = 4'b0000;
        if (hold_valid_q) begin
            out_valid[hold_dst_q] = 1'b1;
        end
    end

    assign out_data = hold_data_q;
    assign sel      = {~hold_dst_q[0], ~hold_dst_q[1]};
    assign demux_in = hold_valid_q;
    assign busy     = hold_valid_q;

`ifdef DEMUX_SCHED_CNT_EN
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];

    // Saturating per-channel output transfer counters.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (xfer && (hold_dst_q == 2'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                cnt_q[i] <= 16'd0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack counters, channel i at bits [16i+15:16i].
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_flat[16*i +: 16] = cnt_q[i];
        end
    end
`else
    assign cnt_flat = 64'd0;
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Randomised plus directed bench for demux_rr_scheduler; two instances (BURST_LEN 1 and 3)
// share stimulus and are compared every cycle against a behavioural model.
module tb_demux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] ch_en;
    logic [3:0] out_ready;

    logic        in_ready  [2];
    logic [3:0]  out_valid [2];
    logic [7:0]  out_data  [2];
    logic [1:0]  sel       [2];
    logic        demux_in  [2];
    logic        busy      [2];
    logic [63:0] cnt_flat  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_rr_scheduler #(.DATA_W(8), .BURST_LEN(1)) u_dut_b1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready[0]),
        .ch_en    (ch_en),
        .out_ready(out_ready),
        .out_valid(out_valid[0]),
        .out_data (out_data[0]),
        .sel      (sel[0]),
        .demux_in (demux_in[0]),
        .busy     (busy[0]),
        .cnt_flat (cnt_flat[0])
    );

    demux_rr_scheduler #(.DATA_W(8), .BURST_LEN(3)) u_dut_b3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready[1]),
        .ch_en    (ch_en),
        .out_ready(out_ready),
        .out_valid(out_valid[1]),
        .out_data (out_data[1]),
        .sel      (sel[1]),
        .demux_in (demux_in[1]),
        .busy     (busy[1]),
        .cnt_flat (cnt_flat[1])
    );

    // Reference model state, one set per instance.
    int burst_len [2] = '{1, 3};
    int sel_code  [4] = '{3, 1, 2, 0};
    int m_valid [2];
    int m_data  [2];
    int m_dst   [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_xfers [2][4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input int m);
        for (int k = 0; k < 4; k++) begin
            if (ch_en[(m_ptr[m] + k) % 4]) return (m_ptr[m] + k) % 4;
        end
        return m_ptr[m];
    endfunction

    function automatic bit model_ready(input int m);
        return (ch_en != 0) && (m_valid[m] == 0 || out_ready[m_dst[m]]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_dst[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
            for (int c = 0; c < 4; c++) m_xfers[m][c] = 0;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            bit xfer;
            bit acc;
            int p;
            xfer = (m_valid[m] != 0) && out_ready[m_dst[m]];
            acc  = in_valid && model_ready(m);
            p    = model_pick(m);
            if (xfer && m_xfers[m][m_dst[m]] < 65535) m_xfers[m][m_dst[m]]++;
            if (acc) begin
                m_valid[m] = 1; m_data[m] = in_data; m_dst[m] = p;
                if (p != m_ptr[m]) begin
                    if (burst_len[m] == 1) begin
                        m_ptr[m] = (p + 1) % 4; m_cnt[m] = 0;
                    end else begin
                        m_ptr[m] = p; m_cnt[m] = 1;
                    end
                end else begin
                    m_cnt[m]++;
                    if (m_cnt[m] == burst_len[m]) begin
                        m_ptr[m] = (p + 1) % 4; m_cnt[m] = 0;
                    end
                end
            end else if (xfer) begin
                m_valid[m] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [63:0] exp_cnt;
            exp_cnt = 64'd0;
`ifdef DEMUX_SCHED_CNT_EN
            for (int c = 0; c < 4; c++) exp_cnt[16*c +: 16] = 16'(m_xfers[m][c]);
`endif
            check($sformatf("in_ready[%0d]", m), 64'(in_ready[m]), 64'(model_ready(m)));
            check($sformatf("out_valid[%0d]", m), 64'(out_valid[m]),
                  m_valid[m] != 0 ? 64'(1 << m_dst[m]) : 64'd0);
            check($sformatf("out_data[%0d]", m), 64'(out_data[m]), 64'(m_data[m]));
            check($sformatf("sel[%0d]", m), 64'(sel[m]), 64'(sel_code[m_dst[m]]));
            check($sformatf("demux_in[%0d]", m), 64'(demux_in[m]), 64'(m_valid[m] != 0));
            check($sformatf("busy[%0d]", m), 64'(busy[m]), 64'(m_valid[m] != 0));
            check($sformatf("cnt_flat[%0d]", m), cnt_flat[m], exp_cnt);
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic [3:0] en, input logic [3:0] rdy);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; ch_en = en; out_ready = rdy;
        #1;
        compare_all();
        @(posedge clk);
        model_clock();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; ch_en = 4'hF; out_ready = 4'hF;
        model_reset();

        // Reset then idle.
        cycle(1, 0, 0, 4'hF, 4'hF);
        cycle(1, 0, 0, 4'hF, 4'hF);
        cycle(0, 0, 0, 4'hF, 4'hF);
        check("reset_sel", 64'(sel[0]), 64'd3);
        check("reset_in_ready", 64'(in_ready[0]), 64'd1);
        check("reset_busy", 64'(busy[1]), 64'd0);
        check("reset_out_valid", 64'(out_valid[1]), 64'd0);

        // Continuous stream.
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'h10 + i), 4'hF, 4'hF);
        cycle(0, 0, 0, 4'hF, 4'hF);

        // Skip disabled channels.
        cycle(1, 0, 0, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'hA0 + i), 4'b1010, 4'hF);
        cycle(0, 0, 0, 4'b1010, 4'hF);

        // Backpressure on channel 0, then transfer and accept in one cycle.
        cycle(1, 0, 0, 4'hF, 4'hF);
        cycle(0, 1, 8'h55, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'h66, 4'hF, 4'h0);
        check("bp_out_valid", 64'(out_valid[0]), 64'd1);
        check("bp_data", 64'(out_data[0]), 64'h55);
        cycle(0, 1, 8'h66, 4'hF, 4'h1);
        cycle(0, 0, 0, 4'hF, 4'hF);

        // Bursts, then ch_en=0 while a word drains.
        cycle(1, 0, 0, 4'hF, 4'hF);
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'(i + 1), 4'hF, 4'hF);
        cycle(0, 1, 8'h77, 4'hF, 4'h0);
        cycle(0, 1, 8'h78, 4'h0, 4'h0);
        cycle(0, 1, 8'h79, 4'h0, 4'hF);
        cycle(0, 0, 0, 4'h0, 4'hF);

        // Reset with a word held on channel 2.
        cycle(1, 0, 0, 4'hF, 4'hF);
        cycle(0, 1, 8'h22, 4'b0100, 4'h0);
        cycle(0, 0, 0, 4'b0100, 4'h0);
        cycle(1, 0, 0, 4'hF, 4'h0);
        cycle(0, 0, 0, 4'hF, 4'h0);
        check("rst_mid_out_valid", 64'(out_valid[1]), 64'd0);

        // Five transfers to channel 1, then reset.
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h30 + i), 4'b0010, 4'hF);
        cycle(0, 0, 0, 4'b0010, 4'hF);
        cycle(0, 0, 0, 4'b0010, 4'hF);
        cycle(1, 0, 0, 4'hF, 4'hF);
        cycle(0, 0, 0, 4'hF, 4'hF);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cycle(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), en,
                  4'($urandom | $urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
